// File: rtl/alu_pkg.sv
// Shared types and helpers for the multi-cycle ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'h0,
    OP_OR    = 4'h1,
    OP_XOR   = 4'h2,
    OP_NOR   = 4'h3,
    OP_ADD   = 4'h4,
    OP_SUB   = 4'h5,
    OP_SLT   = 4'h6,
    OP_SLTU  = 4'h7,
    OP_SLL   = 4'h8,
    OP_SRL   = 4'h9,
    OP_SRA   = 4'hA,
    OP_MUL   = 4'hB,
    OP_MULHU = 4'hC,
    OP_DIVU  = 4'hD,
    OP_REMU  = 4'hE,
    OP_RSV   = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  typedef enum logic [1:0] {
    MD_MUL  = 2'd0,
    MD_MULH = 2'd1,
    MD_DIV  = 2'd2,
    MD_REM  = 2'd3
  } mdu_mode_e;

  typedef struct packed {
    logic zf;
    logic of;
    logic cf;
    logic dz;
  } alu_flags_t;

  // Ops that go through the iterative engine.
  function automatic logic is_multicycle(input alu_op_e o);
    return (o == OP_MUL) || (o == OP_MULHU) || (o == OP_DIVU) || (o == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative engine: shift-add multiply and restoring divide over a shared 2*WIDTH accumulator.
module alu_mdu_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  mdu_mode_e        mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             dz
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;

  logic                 run;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     opd;
  mdu_mode_e            mode_q;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       shifted;
  logic                 geq;

  // One iteration step; acc holds {product_hi, multiplier} or {remainder, quotient}.
  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opd : '0)};
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    geq      = (shifted >= {1'b0, opd});
    acc_next = acc;
    if ((mode_q == MD_MUL) || (mode_q == MD_MULH)) begin
      acc_next = {add_sum, acc[WIDTH-1:1]};
    end else begin
      acc_next = {(geq ? WIDTH'(shifted - {1'b0, opd}) : shifted[WIDTH-1:0]),
                  acc[WIDTH-2:0], geq};
    end
    done = run && (cnt == CW'(WIDTH - 1));
    res  = ((mode_q == MD_MUL) || (mode_q == MD_DIV)) ? acc_next[WIDTH-1:0]
                                                      : acc_next[2*WIDTH-1:WIDTH];
  end

  // Load on start, then iterate WIDTH times; done marks the final iteration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      opd    <= '0;
      mode_q <= MD_MUL;
      dz     <= 1'b0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= '0;
      acc    <= {{WIDTH{1'b0}}, a};
      opd    <= b;
      mode_q <= mode;
      dz     <= ((mode == MD_DIV) || (mode == MD_REM)) && (b == '0);
    end else if (run) begin
      acc <= acc_next;
      cnt <= cnt + CW'(1);
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake; single-cycle ops inline, MUL/DIV via engine.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             of,
  output logic             cf,
  output logic             dz
);

  localparam int unsigned SHW = $clog2(WIDTH);

  alu_state_e       state, state_d;
  logic             ld, take, mdu_start, mdu_done, mdu_dz;
  mdu_mode_e        mdu_mode;
  logic [WIDTH-1:0] mdu_res, sc_res, res_d;
  alu_flags_t       sc_flg, flg_d;
  logic [WIDTH:0]   sum, dif;
  logic [SHW-1:0]   shamt;

  assign out_valid = (state == ST_DONE);
  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);

  // Single-cycle datapath and engine mode decode.
  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    dif      = {1'b0, a} - {1'b0, b};
    shamt    = b[SHW-1:0];
    sc_res   = '0;
    sc_flg   = '0;
    mdu_mode = MD_MUL;
    case (alu_op_e'(op))
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_NOR:  sc_res = ~(a | b);
      OP_ADD: begin
        sc_res    = sum[WIDTH-1:0];
        sc_flg.cf = sum[WIDTH];
        sc_flg.of = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res    = dif[WIDTH-1:0];
        sc_flg.cf = dif[WIDTH];
        sc_flg.of = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:   sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:  sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:   sc_res = a << shamt;
      OP_SRL:   sc_res = a >> shamt;
      OP_SRA:   sc_res = $signed(a) >>> shamt;
      OP_MULHU: mdu_mode = MD_MULH;
      OP_DIVU:  mdu_mode = MD_DIV;
      OP_REMU:  mdu_mode = MD_REM;
      default:  sc_res = '0;
    endcase
    sc_flg.zf = (sc_res == '0);
  end

  // Next-state and output-load decisions.
  always_comb begin
    state_d   = state;
    ld        = 1'b0;
    take      = 1'b0;
    mdu_start = 1'b0;
    res_d     = sc_res;
    flg_d     = sc_flg;
    case (state)
      ST_IDLE: take = in_valid;
      ST_BUSY: begin
        if (mdu_done) begin
          ld      = 1'b1;
          res_d   = mdu_res;
          flg_d   = '{zf: (mdu_res == '0), of: 1'b0, cf: 1'b0, dz: mdu_dz};
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          if (in_valid) take = 1'b1;
          else          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (take) begin
      if (is_multicycle(alu_op_e'(op))) begin
        mdu_start = 1'b1;
        state_d   = ST_BUSY;
      end else begin
        ld      = 1'b1;
        state_d = ST_DONE;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Result and flag registers, held while waiting for the consumer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
      zf     <= 1'b0;
      of     <= 1'b0;
      cf     <= 1'b0;
      dz     <= 1'b0;
    end else if (ld) begin
      result <= res_d;
      zf     <= flg_d.zf;
      of     <= flg_d.of;
      cf     <= flg_d.cf;
      dz     <= flg_d.dz;
    end
  end

  alu_mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mdu_start),
    .mode  (mdu_mode),
    .a     (a),
    .b     (b),
    .done  (mdu_done),
    .res   (mdu_res),
    .dz    (mdu_dz)
  );

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: random and directed ops against a behavioural model.
module tb_alu_mc;

  localparam int unsigned W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 64'sd1;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   op;
  logic [W-1:0] a, b, result;
  logic         zf, of, cf, dz;

  typedef struct {
    logic [W-1:0] res;
    logic         zf, of, cf, dz;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0, fails = 0, cyc = 0;
  bit   bp_mode = 0;
  bit   seen = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zf(zf), .of(of), .cf(cf), .dz(dz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    longint      sx, sy, s;
    logic [63:0] p;
    int          sh;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(y[4:0]);
    e.res = '0; e.zf = 0; e.of = 0; e.cf = 0; e.dz = 0; e.lat = 1; e.acc = 0;
    case (o)
      4'h0: e.res = x & y;
      4'h1: e.res = x | y;
      4'h2: e.res = x ^ y;
      4'h3: e.res = ~(x | y);
      4'h4: begin
        p = {32'b0, x} + {32'b0, y};
        e.res = p[31:0]; e.cf = p[32];
        s = sx + sy; e.of = (s > SMAX) || (s < SMIN);
      end
      4'h5: begin
        e.res = x - y; e.cf = (x < y);
        s = sx - sy; e.of = (s > SMAX) || (s < SMIN);
      end
      4'h6: e.res = (sx < sy) ? 32'd1 : 32'd0;
      4'h7: e.res = (x < y) ? 32'd1 : 32'd0;
      4'h8: e.res = x << sh;
      4'h9: e.res = x >> sh;
      4'hA: e.res = $signed(x) >>> sh;
      4'hB: begin p = 64'(x) * 64'(y); e.res = p[31:0];  e.lat = W + 1; end
      4'hC: begin p = 64'(x) * 64'(y); e.res = p[63:32]; e.lat = W + 1; end
      4'hD: begin
        e.lat = W + 1;
        if (y == 0) begin e.res = '1; e.dz = 1; end else e.res = x / y;
      end
      4'hE: begin
        e.lat = W + 1;
        if (y == 0) begin e.res = x; e.dz = 1; end else e.res = x % y;
      end
      default: e.res = '0;
    endcase
    e.zf = (e.res == 0);
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
    in_valid = 1'b0;
    if (bp_mode) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e = model(o, x, y);
    e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int g = 0;
    bit fin = 0;
    while (!fin) begin
      tick();
      in_valid = 1'b1; op = o; a = x; b = y;
      #1;
      if (in_ready) begin
        push(o, x, y);
        fin = 1;
      end else if (++g > 200) begin
        tests++; fails++;
        $display("FAIL issue_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, g);
        fin = 1;
      end
    end
  endtask

  task automatic wait_valid();
    int g = 0;
    #1;
    while (!out_valid && g < 100) begin tick(); #1; g++; end
    if (!out_valid) begin
      tests++; fails++;
      $display("FAIL wait_valid: out_valid=%0b, required 1 within 100 cycles", out_valid);
    end
  endtask

  task automatic drain();
    int g = 0;
    bp_mode = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && g < 500) begin tick(); g++; end
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      sb.delete();
      seen = 0;
    end
  endtask

  task automatic check_reset(input string name);
    logic [37:0] got;
    got = {out_valid, in_ready, result, zf, of, cf, dz};
    tests++;
    if (got !== {1'b0, 1'b1, 32'h0, 4'h0}) begin
      fails++;
      $display("FAIL %s: got {ov,ir,res,flags}=%h, required %h", name, got, {1'b0, 1'b1, 32'h0, 4'h0});
    end
  endtask

  // Monitor: compare every presented result against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output: result=%h with empty scoreboard", result);
        end else begin
          e = sb[0];
          if ({result, zf, of, cf, dz} !== {e.res, e.zf, e.of, e.cf, e.dz}) begin
            fails++;
            $display("FAIL result: got res=%h zf=%0b of=%0b cf=%0b dz=%0b, required res=%h zf=%0b of=%0b cf=%0b dz=%0b",
                     result, zf, of, cf, dz, e.res, e.zf, e.of, e.cf, e.dz);
          end
          if (!seen) begin
            seen = 1;
            tests++;
            if (cyc - e.acc != e.lat) begin
              fails++;
              $display("FAIL latency: got %0d cycles, required %0d", cyc - e.acc, e.lat);
            end
          end
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    repeat (3) tick();
    #1;
    check_reset("reset_state");
    rst_n = 1'b1;

    // Directed arithmetic, compare and shift cases.
    issue(4'h4, 32'h7FFFFFFF, 32'h1);
    issue(4'h4, 32'hFFFFFFFF, 32'h1);
    issue(4'h5, 32'd5, 32'd7);
    issue(4'h6, 32'hFFFFFFFF, 32'h1);
    issue(4'h7, 32'hFFFFFFFF, 32'h1);
    issue(4'hA, 32'h80000000, 32'h00000124);
    issue(4'hF, 32'h12345678, 32'h9ABCDEF0);
    issue(4'hC, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(4'hB, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(4'hD, 32'd100, 32'd7);
    issue(4'hE, 32'd100, 32'd7);
    drain();

    // Reset while the engine is busy.
    issue(4'hD, 32'd1000, 32'd3);
    repeat (5) tick();
    rst_n = 1'b0;
    sb.delete();
    seen = 0;
    tick();
    #1;
    check_reset("reset_mid_busy");
    rst_n = 1'b1;
    issue(4'h4, 32'd3, 32'd4);
    drain();

    // Divide by zero held under backpressure, then simultaneous out/in fire.
    tick();
    out_ready = 1'b0;
    issue(4'hD, 32'd9, 32'd0);
    wait_valid();
    repeat (10) tick();
    tick();
    out_ready = 1'b1;
    in_valid = 1'b1; op = 4'h0; a = 32'hF0F0_1234; b = 32'h0FF0_FF00;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL back_to_back_ready: in_ready=%0b, required 1", in_ready);
    end else push(4'h0, a, b);
    tick();
    drain();

    // Randomised traffic with random backpressure.
    bp_mode = 1;
    for (int i = 0; i < 300; i++) begin
      logic [3:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 4'($urandom_range(0, 15));
      ra = $urandom();
      case ($urandom_range(0, 5))
        0:       rb = 32'($urandom_range(0, 40));
        1:       rb = 32'h0;
        2:       rb = ra;
        default: rb = $urandom();
      endcase
      if ($urandom_range(0, 3) == 0) tick();
      issue(ro, ra, rb);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
